// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue stage sitting directly in front of the ALU. It takes a decoded
//   instruction, resolves both source operands through EX/WB forwarding and
//   the immediate mux, and holds the result in an output register that the
//   ALU consumes through a valid/ready handshake. A load still in EX, whose
//   result is needed, stalls decode; each stalled cycle is counted in a
//   saturating debug counter.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   flush               drop the held instruction and block capture
//   dec_*               decoded instruction, register-file data, immediate
//   dec_ready           stage accepts the decode instruction this cycle
//   ex_fwd_*            EX-stage result in flight (pending = load not done)
//   wb_fwd_*            writeback result
//   alu_valid/alu_ready handshake to the ALU
//   ALU_A_in, ALU_B_in  resolved operands
//   opcode, alu_rd      registered opcode and destination index
//   stall_cnt           saturating count of hazard-stall cycles
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [OP_W-1:0]   dec_opcode,
  input  logic [REG_W-1:0]  dec_rs1,
  input  logic [REG_W-1:0]  dec_rs2,
  input  logic [REG_W-1:0]  dec_rd,
  input  logic [DATA_W-1:0] dec_rs1_data,
  input  logic [DATA_W-1:0] dec_rs2_data,
  input  logic [DATA_W-1:0] dec_imm,
  input  logic              dec_use_imm,
  input  logic              ex_fwd_valid,
  input  logic [REG_W-1:0]  ex_fwd_rd,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              ex_fwd_pending,
  input  logic              wb_fwd_valid,
  input  logic [REG_W-1:0]  wb_fwd_rd,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [DATA_W-1:0] ALU_A_in,
  output logic [DATA_W-1:0] ALU_B_in,
  output logic [OP_W-1:0]   opcode,
  output logic [REG_W-1:0]  alu_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Resolve one source register: x0 is hard zero, then the youngest
  // available producer (EX, unless it is a load still pending), then WB,
  // then the register file.
  function automatic logic signed [DATA_W-1:0] fwd_sel(
    input logic [REG_W-1:0]         idx,
    input logic signed [DATA_W-1:0] rf_data,
    input logic                     ex_vld,
    input logic                     ex_pend,
    input logic [REG_W-1:0]         ex_rd,
    input logic signed [DATA_W-1:0] ex_data,
    input logic                     wb_vld,
    input logic [REG_W-1:0]         wb_rd,
    input logic signed [DATA_W-1:0] wb_data
  );
    logic signed [DATA_W-1:0] res;
    if (idx == '0)
      res = '0;
    else if (ex_vld && !ex_pend && (ex_rd == idx))
      res = ex_data;
    else if (wb_vld && (wb_rd == idx))
      res = wb_data;
    else
      res = rf_data;
    return res;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (v == '1) ? v : v + one;
  endfunction

  logic                     hazard_p0;
  logic                     rs1_hit_p0;
  logic                     rs2_hit_p0;
  logic                     capture_p0;
  logic signed [DATA_W-1:0] rs2_fwd_p0;
  logic signed [DATA_W-1:0] opa_p0;
  logic signed [DATA_W-1:0] opb_p0;

  logic                     vld_p1;
  logic signed [DATA_W-1:0] opa_p1;
  logic signed [DATA_W-1:0] opb_p1;
  logic [OP_W-1:0]          op_p1;
  logic [REG_W-1:0]         rd_p1;
  logic [CNT_W-1:0]         stall_cnt_q;

  // ---- p0: decode-side hazard check and operand resolution ----
  // rs2 only matters when the immediate is not replacing it; the opcode
  // plays no part in the decision.
  assign rs1_hit_p0 = (dec_rs1 == ex_fwd_rd);
  assign rs2_hit_p0 = !dec_use_imm && (dec_rs2 == ex_fwd_rd);
  assign hazard_p0  = dec_valid && ex_fwd_valid && ex_fwd_pending &&
                      (ex_fwd_rd != '0) && (rs1_hit_p0 || rs2_hit_p0);

  assign dec_ready  = !hazard_p0 && !flush && (!vld_p1 || alu_ready);
  assign capture_p0 = dec_valid && dec_ready;

  assign opa_p0 = fwd_sel(dec_rs1, dec_rs1_data, ex_fwd_valid, ex_fwd_pending,
                          ex_fwd_rd, ex_fwd_data, wb_fwd_valid, wb_fwd_rd,
                          wb_fwd_data);
  assign rs2_fwd_p0 = fwd_sel(dec_rs2, dec_rs2_data, ex_fwd_valid,
                              ex_fwd_pending, ex_fwd_rd, ex_fwd_data,
                              wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
  assign opb_p0 = dec_use_imm ? dec_imm : rs2_fwd_p0;

  // ---- p1: registered operands presented to the ALU ----
  // Flush wins over capture (dec_ready already excludes it); a drain with
  // no new capture leaves a bubble. Data registers are left alone on flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      opa_p1      <= '0;
      opb_p1      <= '0;
      op_p1       <= '0;
      rd_p1       <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush)
        vld_p1 <= 1'b0;
      else if (capture_p0)
        vld_p1 <= 1'b1;
      else if (alu_ready)
        vld_p1 <= 1'b0;

      if (capture_p0) begin
        opa_p1 <= opa_p0;
        opb_p1 <= opb_p0;
        op_p1  <= dec_opcode;
        rd_p1  <= dec_rd;
      end

      if (hazard_p0)
        stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign alu_valid = vld_p1;
  assign ALU_A_in  = opa_p1;
  assign ALU_B_in  = opb_p1;
  assign opcode    = op_p1;
  assign alu_rd    = rd_p1;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int OW = 5;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          dec_valid;
  logic          dec_ready;
  logic [OW-1:0] dec_opcode;
  logic [RW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [DW-1:0] dec_rs1_data, dec_rs2_data, dec_imm;
  logic          dec_use_imm;
  logic          ex_fwd_valid;
  logic [RW-1:0] ex_fwd_rd;
  logic [DW-1:0] ex_fwd_data;
  logic          ex_fwd_pending;
  logic          wb_fwd_valid;
  logic [RW-1:0] wb_fwd_rd;
  logic [DW-1:0] wb_fwd_data;
  logic          alu_valid;
  logic          alu_ready;
  logic [DW-1:0] ALU_A_in, ALU_B_in;
  logic [OW-1:0] opcode;
  logic [RW-1:0] alu_rd;
  logic [CW-1:0] stall_cnt;

  alu_issue_stage #(.DATA_W(DW), .REG_W(RW), .OP_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd),
    .ex_fwd_data(ex_fwd_data), .ex_fwd_pending(ex_fwd_pending),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .ALU_A_in(ALU_A_in), .ALU_B_in(ALU_B_in), .opcode(opcode),
    .alu_rd(alu_rd), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what the ALU should currently be seeing.
  logic          m_valid;
  logic [DW-1:0] m_a, m_b;
  logic [OW-1:0] m_op;
  logic [RW-1:0] m_rd;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_hazard();
    if (!(dec_valid && ex_fwd_valid && ex_fwd_pending && ex_fwd_rd != 0)) return 1'b0;
    if (dec_rs1 == ex_fwd_rd) return 1'b1;
    if (!dec_use_imm && dec_rs2 == ex_fwd_rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] ref_src(input logic [RW-1:0] idx, input logic [DW-1:0] rf);
    if (idx == 0) return '0;
    if (ex_fwd_valid && !ex_fwd_pending && ex_fwd_rd == idx) return ex_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd == idx) return wb_fwd_data;
    return rf;
  endfunction

  // One clock: check the combinational ready, advance the model with the
  // inputs present at the edge, then check the registered outputs.
  task automatic cycle();
    logic haz, rdy, cap;
    #1;
    haz = ref_hazard();
    rdy = !haz && !flush && (!m_valid || alu_ready);
    cap = dec_valid && rdy;
    chk("dec_ready", dec_ready, rdy);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_cnt = 0;
    end else begin
      if (haz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (flush) m_valid = 0;
      else if (cap) begin
        m_valid = 1;
        m_a  = ref_src(dec_rs1, dec_rs1_data);
        m_b  = dec_use_imm ? dec_imm : ref_src(dec_rs2, dec_rs2_data);
        m_op = dec_opcode;
        m_rd = dec_rd;
      end else if (alu_ready) m_valid = 0;
    end
    #1;
    chk("alu_valid", alu_valid, m_valid);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (m_valid) begin
      chk("ALU_A_in", ALU_A_in, m_a);
      chk("ALU_B_in", ALU_B_in, m_b);
      chk("opcode", opcode, m_op);
      chk("alu_rd", alu_rd, m_rd);
    end
  endtask

  task automatic idle();
    flush = 0; dec_valid = 0; dec_use_imm = 0; dec_opcode = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_rs1_data = 0; dec_rs2_data = 0; dec_imm = 0;
    ex_fwd_valid = 0; ex_fwd_rd = 0; ex_fwd_data = 0; ex_fwd_pending = 0;
    wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    alu_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0; cycle(); rst_n = 1;
  endtask

  logic [DW-1:0] hold_a, hold_b;

  initial begin
    m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_cnt = 0;
    idle();
    rst_n = 0;

    // Reset held two cycles with decode valid.
    dec_valid = 1; dec_opcode = 5'h03; dec_rs1 = 1; dec_rs1_data = 32'h1234;
    dec_rs2 = 2; dec_rs2_data = 32'h5678; dec_rd = 7;
    cycle(); cycle();
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_A", ALU_A_in, 0);
    chk("rst_B", ALU_B_in, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_rd", alu_rd, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst_n = 1;
    cycle();
    chk("first_cap_valid", alu_valid, 1);
    chk("first_cap_A", ALU_A_in, 32'h1234);
    chk("first_cap_B", ALU_B_in, 32'h5678);

    // Forwarding priority on rs1.
    dec_rs1 = 3; dec_rs1_data = 32'h33;
    ex_fwd_valid = 1; ex_fwd_rd = 3; ex_fwd_data = 32'h11;
    wb_fwd_valid = 1; wb_fwd_rd = 3; wb_fwd_data = 32'h22;
    cycle(); chk("fwd_ex", ALU_A_in, 32'h11);
    ex_fwd_valid = 0;
    cycle(); chk("fwd_wb", ALU_A_in, 32'h22);
    wb_fwd_valid = 0;
    cycle(); chk("fwd_rf", ALU_A_in, 32'h33);

    // x0 and immediate.
    dec_rs1 = 0; dec_rs1_data = 32'hDEAD;
    ex_fwd_valid = 1; ex_fwd_rd = 0; ex_fwd_data = 32'hFF;
    cycle(); chk("x0_zero", ALU_A_in, 0);
    dec_use_imm = 1; dec_imm = 32'hFFFFFFF0; dec_rs2 = 4; ex_fwd_rd = 4;
    wb_fwd_valid = 1; wb_fwd_rd = 4;
    cycle(); chk("imm_B", ALU_B_in, 32'hFFFFFFF0);
    idle();

    // Load-use: one instruction in flight drains during the stall.
    do_reset();
    dec_valid = 1; dec_opcode = 5'h01; dec_rs1 = 1; dec_rs1_data = 32'h10; dec_rd = 9;
    cycle();
    dec_opcode = 5'h09; dec_rs1 = 2; dec_rs1_data = 32'h20; dec_rs2 = 5;
    dec_rs2_data = 32'h55; dec_rd = 6; dec_use_imm = 0;
    ex_fwd_valid = 1; ex_fwd_rd = 5; ex_fwd_data = 32'hABCD; ex_fwd_pending = 1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("lu_ready", dec_ready, 0);
      cycle();
      chk("lu_bubble", alu_valid, 0);
    end
    chk("lu_cnt", stall_cnt, 3);
    ex_fwd_pending = 0;
    cycle();
    chk("lu_cap_valid", alu_valid, 1);
    chk("lu_cap_B", ALU_B_in, 32'hABCD);
    chk("lu_cap_op", opcode, 5'h09);
    idle();

    // Backpressure then streaming.
    dec_valid = 1; dec_opcode = 5'h0A; dec_rs1 = 1; dec_rs1_data = 32'hA1;
    dec_rs2 = 2; dec_rs2_data = 32'hB2; dec_rd = 3;
    cycle();
    hold_a = ALU_A_in; hold_b = ALU_B_in;
    alu_ready = 0; dec_opcode = 5'h0B; dec_rs1_data = 32'hC3; dec_rs2_data = 32'hD4;
    for (int i = 0; i < 4; i++) begin
      #1; chk("bp_ready", dec_ready, 0);
      cycle();
      chk("bp_A_stable", ALU_A_in, hold_a);
      chk("bp_B_stable", ALU_B_in, hold_b);
      chk("bp_op_stable", opcode, 5'h0A);
    end
    alu_ready = 1;
    for (int i = 0; i < 4; i++) begin
      dec_opcode = 5'(5'h10 + i); dec_rs1_data = 32'(i * 3 + 1);
      cycle();
      chk("stream_valid", alu_valid, 1);
      chk("stream_op", opcode, 5'(5'h10 + i));
    end

    // Flush on a capture cycle.
    flush = 1; dec_opcode = 5'h1F;
    cycle();
    chk("flush_valid", alu_valid, 0);
    flush = 0; dec_valid = 0;
    cycle(); cycle();
    chk("flush_never", alu_valid, 0);
    idle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      rst_n          = ($urandom_range(0, 63) != 0);
      flush          = ($urandom_range(0, 15) == 0);
      dec_valid      = ($urandom_range(0, 3) != 0);
      dec_opcode     = 5'($urandom);
      dec_rs1        = 5'($urandom_range(0, 7));
      dec_rs2        = 5'($urandom_range(0, 7));
      dec_rd         = 5'($urandom);
      dec_rs1_data   = $urandom;
      dec_rs2_data   = $urandom;
      dec_imm        = $urandom;
      dec_use_imm    = 1'($urandom);
      ex_fwd_valid   = 1'($urandom);
      ex_fwd_rd      = 5'($urandom_range(0, 7));
      ex_fwd_data    = $urandom;
      ex_fwd_pending = ($urandom_range(0, 3) == 0);
      wb_fwd_valid   = 1'($urandom);
      wb_fwd_rd      = 5'($urandom_range(0, 7));
      wb_fwd_data    = $urandom;
      alu_ready      = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle(); rst_n = 1;

    // Counter saturation: drive hazards until one short of all-ones.
    do_reset();
    dec_valid = 1; dec_rs1 = 5; ex_fwd_valid = 1; ex_fwd_rd = 5; ex_fwd_pending = 1;
    for (int i = 0; i < 70000 && m_cnt < 16'hFFFE; i++) cycle();
    chk("sat_pre", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) cycle();
    chk("sat_hold", stall_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU. Captures decoded instructions and resolves operands with EX/WB forwarding and the immediate mux.
- Detects load-use hazards and stalls decode when one is present.
- Presents registered opcode and A/B operands to the ALU through a valid/ready handshake.
- Includes a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, operand/result width; matches the ALU operand width.
- REG_W, 5, register index width.
- OP_W, 5, opcode width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  discard the held instruction (branch/exception).
- dec_valid  in  1  decode presents an instruction.
- dec_ready  out  1  stage accepts the instruction this cycle.
- dec_opcode  in  OP_W  instruction opcode.
- dec_rs1, dec_rs2, dec_rd  in  REG_W  source and destination register indices.
- dec_rs1_data, dec_rs2_data  in  DATA_W  register-file read data.
- dec_imm  in  DATA_W  sign-extended immediate.
- dec_use_imm  in  1  select the immediate as operand B.
- ex_fwd_valid, ex_fwd_rd, ex_fwd_data  in  1/REG_W/DATA_W  EX-stage result in flight.
- ex_fwd_pending  in  1  EX result is not yet available (load).
- wb_fwd_valid, wb_fwd_rd, wb_fwd_data  in  1/REG_W/DATA_W  writeback result.
- alu_valid  out  1  operands valid to the ALU.
- alu_ready  in  1  downstream accepts.
- ALU_A_in, ALU_B_in  out  DATA_W  resolved operands.
- opcode  out  OP_W  registered opcode.
- alu_rd  out  REG_W  destination index, carried forward.
- stall_cnt  out  CNT_W  number of hazard-stall cycles.

Behaviour:

Reset:
- When rst_n=0 at a clock edge, on the next cycle: alu_valid=0; ALU_A_in, ALU_B_in, opcode, alu_rd = 0; stall_cnt=0.
- Reset overrides flush and any capture in progress.

Hazard:
- hazard = dec_valid & ex_fwd_valid & ex_fwd_pending & (ex_fwd_rd != 0) & ((dec_rs1 == ex_fwd_rd) | (~dec_use_imm & (dec_rs2 == ex_fwd_rd))).
- NOT (5'b01001) still checks rs2 when dec_use_imm=0. Hazard detection is not opcode-dependent.

Ready:
- dec_ready = ~hazard & ~flush & (~alu_valid | alu_ready). Combinational.

Forwarding (per source, combinational, evaluated before capture):
- Priority 1: register index 0 always resolves to 0.
- Priority 2: EX match (ex_fwd_valid, rd equal, ~ex_fwd_pending) -> ex_fwd_data.
- Priority 3: WB match -> wb_fwd_data.
- Otherwise: register-file data.
- Operand B = dec_imm when dec_use_imm=1; otherwise the forwarded rs2 value.

Capture:
- On an edge with dec_valid & dec_ready: register the operands, opcode and rd; alu_valid becomes 1 in the next cycle.
- Latency is one cycle from acceptance to alu_valid.

Hold:
- While alu_valid=1 & alu_ready=0, all outputs remain stable.

Drain and bubble:
- If alu_ready=1 and no capture occurs, alu_valid becomes 0.
- A hazard therefore inserts exactly one bubble per stalled cycle once the held instruction drains.

Flush:
- flush=1 at an edge clears alu_valid and blocks capture that cycle.
- Data registers may retain stale values. Flush has priority over capture but not over reset.

Stall counter:
- stall_cnt increments on each edge where hazard=1.
- Saturates at all-ones; no wrap.

Back-to-back flow:
- Simultaneous drain and capture (alu_valid & alu_ready & dec_valid & dec_ready) sustains one instruction per cycle with no gap.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with dec_valid=1 -> alu_valid=0, ALU_A_in=0, ALU_B_in=0, stall_cnt=0. Deassert reset -> first capture appears 1 cycle later.
- Forwarding priority: rs1=3, ex_fwd_rd=3 with data 0x11, wb_fwd_rd=3 with data 0x22, rf data 0x33 -> ALU_A_in=0x11. Drop EX valid -> 0x22. Drop WB valid -> 0x33.
- Register 0 and immediate: rs1=0 with EX forwarding rd=0 data 0xFF -> ALU_A_in=0. dec_use_imm=1, imm=0xFFFFFFF0 -> ALU_B_in=0xFFFFFFF0 regardless of rs2 forwarding.
- Load-use: ex_fwd_pending=1 with rd=5, dec_rs2=5, use_imm=0 for 3 cycles -> dec_ready=0 for 3 cycles, alu_valid drops after drain, stall_cnt=3. Release pending -> capture with the EX data.
- Backpressure: alu_ready=0 for 4 cycles with a valid held instruction -> outputs stable, dec_ready=0. alu_ready=1 with a streaming decode -> 1 instruction per cycle.
- Flush: flush=1 on the same cycle as a valid capture -> alu_valid=0 next cycle and that instruction never reaches the ALU. stall_cnt preset to 0xFFFE, 3 hazard cycles -> stall_cnt=0xFFFF.
